// File: rtl/char_line_pkg.sv
// Shared constants and write-side state encoding for the character line receiver.
package char_line_pkg;
  localparam logic [7:0] CHAR_IDLE = 8'h00;
  localparam logic [7:0] CHAR_NL   = 8'h0A;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    PENDING = 2'd2
  } wstate_e;
endpackage

// File: rtl/char_line_ram.sv
// Ping-pong line storage: bank bit is the address MSB, sync write, async read.
module char_line_ram
  import char_line_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH):0]   waddr,
  input  logic [7:0]               wdata,
  input  logic [$clog2(DEPTH):0]   raddr,
  output logic [7:0]               rdata
);
  logic [7:0] mem [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/char_line_rx.sv
// Assembles newline-terminated lines into one bank while the other bank is
// replayed on a ready-paced output character stream.
module char_line_rx
  import char_line_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  output logic [7:0] out,
  input  logic       out_ready,
  output logic       line_done,
  output logic       overflow,
  output logic       busy
);
  localparam int unsigned AW = $clog2(DEPTH);

  wstate_e       state, state_nxt;
  logic [AW-1:0] wptr;
  logic [AW:0]   rptr, rlen;
  logic          wsel;
  logic          we, drop, swap;
  logic          is_char, is_nl, rd_free;
  logic [7:0]    rd_data;

  assign is_char = (in != CHAR_IDLE);
  assign is_nl   = (in == CHAR_NL);
  assign rd_free = (rlen == rptr);
  assign busy    = (rptr < rlen) || (state == PENDING);

  char_line_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wsel, wptr}),
    .wdata (in),
    .raddr ({~wsel, rptr[AW-1:0]}),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    drop      = 1'b0;
    swap      = 1'b0;
    case (state)
      FILL, DISCARD: begin
        if (is_nl) begin
          // Newline always lands in the write bank; commit now or wait.
          we        = 1'b1;
          swap      = rd_free;
          state_nxt = rd_free ? FILL : PENDING;
        end else if (is_char) begin
          if (state == DISCARD || wptr == AW'(DEPTH-1)) begin
            drop      = 1'b1;
            state_nxt = DISCARD;
          end else begin
            we = 1'b1;
          end
        end
      end
      PENDING: begin
        drop = is_char;
        if (rd_free) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out       <= CHAR_IDLE;
      line_done <= 1'b0;
      overflow  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      rlen      <= '0;
      wsel      <= 1'b0;
    end else begin
      line_done <= swap;
      overflow  <= drop;
      out       <= CHAR_IDLE;
      if (out_ready && (rptr < rlen)) begin
        out  <= rd_data;
        rptr <= rptr + 1'b1;
      end
      if (swap) begin
        wsel <= ~wsel;
        rlen <= {1'b0, wptr} + 1'b1;
        rptr <= '0;
        wptr <= '0;
      end else if (we && !is_nl) begin
        wptr <= wptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_char_line_rx.sv
// Directed self-checking bench for char_line_rx.
module tb_char_line_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rdy = 1'b0;
  logic [7:0] out;
  logic       line_done, overflow, busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  char_line_rx #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .out       (out),
    .out_ready (rdy),
    .line_done (line_done),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c;
    logic       r;
    logic [7:0] o;
    logic       ld;
    logic       ov;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [7:0] c, input logic r, input logic [7:0] o,
                             input logic ld, input logic ov, input logic b);
    vec_t t;
    t.c = c; t.r = r; t.o = o; t.ld = ld; t.ov = ov; t.b = b;
    return t;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] c, input logic r);
    din = c;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [7:0] o, input logic ld,
                            input logic ov, input logic b);
    chk({tag, ".out"}, out, o);
    chk({tag, ".line_done"}, {7'd0, line_done}, {7'd0, ld});
    chk({tag, ".overflow"}, {7'd0, overflow}, {7'd0, ov});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
  endtask

  int unsigned ov_cnt;
  string       hello;

  initial begin
    // Basic line, ready held high.
    tbl.push_back(v("x",   1, 8'h00, 0, 0, 0));
    tbl.push_back(v("y",   1, 8'h00, 0, 0, 0));
    tbl.push_back(v("z",   1, 8'h00, 0, 0, 0));
    tbl.push_back(v(8'h0A, 1, 8'h00, 1, 0, 1));
    tbl.push_back(v(8'h00, 1, "x",   0, 0, 1));
    tbl.push_back(v(8'h00, 1, "y",   0, 0, 1));
    tbl.push_back(v(8'h00, 1, "z",   0, 0, 1));
    tbl.push_back(v(8'h00, 1, 8'h0A, 0, 0, 0));
    tbl.push_back(v(8'h00, 1, 8'h00, 0, 0, 0));
    // Same line, ready toggling.
    tbl.push_back(v("x",   1, 8'h00, 0, 0, 0));
    tbl.push_back(v("y",   0, 8'h00, 0, 0, 0));
    tbl.push_back(v("z",   1, 8'h00, 0, 0, 0));
    tbl.push_back(v(8'h0A, 0, 8'h00, 1, 0, 1));
    tbl.push_back(v(8'h00, 1, "x",   0, 0, 1));
    tbl.push_back(v(8'h00, 0, 8'h00, 0, 0, 1));
    tbl.push_back(v(8'h00, 1, "y",   0, 0, 1));
    tbl.push_back(v(8'h00, 0, 8'h00, 0, 0, 1));
    tbl.push_back(v(8'h00, 1, "z",   0, 0, 1));
    tbl.push_back(v(8'h00, 0, 8'h00, 0, 0, 1));
    tbl.push_back(v(8'h00, 1, 8'h0A, 0, 0, 0));
    tbl.push_back(v(8'h00, 0, 8'h00, 0, 0, 0));

    // Reset for 10 cycles.
    rst = 1'b0;
    repeat (10) step(8'h00, 1'b1);
    expect_all("reset", 8'h00, 0, 0, 0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].r);
      expect_all($sformatf("vec%0d", i), tbl[i].o, tbl[i].ld, tbl[i].ov, tbl[i].b);
    end

    // 20 chars into a 16-deep line: 15 kept, 5 dropped, then newline.
    ov_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(8'h41 + 8'(i), 1'b0);
      if (overflow) ov_cnt++;
      chk($sformatf("ovf.pulse%0d", i), {7'd0, overflow}, (i >= 15) ? 8'd1 : 8'd0);
    end
    chk("ovf.count", 8'(ov_cnt), 8'd5);
    step(8'h0A, 1'b0);
    expect_all("ovf.nl", 8'h00, 1, 0, 1);
    for (int k = 0; k < 17; k++) begin
      step(8'h00, 1'b1);
      chk($sformatf("ovf.out%0d", k), out,
          (k < 15) ? 8'h41 + 8'(k) : ((k == 15) ? 8'h0A : 8'h00));
    end
    chk("ovf.busy_end", {7'd0, busy}, 8'd0);

    // Line A then B while stalled: B waits in PENDING, third line is dropped.
    step("a",   1'b0); expect_all("pend.a",  8'h00, 0, 0, 0);
    step("b",   1'b0);
    step(8'h0A, 1'b0); expect_all("pend.nlA", 8'h00, 1, 0, 1);
    step("c",   1'b0); expect_all("pend.c",  8'h00, 0, 0, 1);
    step("d",   1'b0);
    step(8'h0A, 1'b0); expect_all("pend.nlB", 8'h00, 0, 0, 1);
    step("e",   1'b0); expect_all("pend.drop_e",  8'h00, 0, 1, 1);
    step(8'h0A, 1'b0); expect_all("pend.drop_nl", 8'h00, 0, 1, 1);
    step(8'h00, 1'b0); expect_all("pend.idle",    8'h00, 0, 0, 1);
    step(8'h00, 1'b1); expect_all("pend.oa",  "a",   0, 0, 1);
    step(8'h00, 1'b1); expect_all("pend.ob",  "b",   0, 0, 1);
    step(8'h00, 1'b1); expect_all("pend.onl", 8'h0A, 0, 0, 1);
    step(8'h00, 1'b1); expect_all("pend.swap", 8'h00, 1, 0, 1);
    step(8'h00, 1'b1); expect_all("pend.oc",  "c",   0, 0, 1);
    step(8'h00, 1'b1); expect_all("pend.od",  "d",   0, 0, 1);
    step(8'h00, 1'b1); expect_all("pend.onl2", 8'h0A, 0, 0, 0);
    step(8'h00, 1'b1); expect_all("pend.end", 8'h00, 0, 0, 0);

    // Bare newline.
    step(8'h0A, 1'b1); expect_all("bare.nl",  8'h00, 1, 0, 1);
    step(8'h00, 1'b1); expect_all("bare.out", 8'h0A, 0, 0, 0);
    step(8'h00, 1'b1); expect_all("bare.end", 8'h00, 0, 0, 0);

    // Reset mid-drain, then a fresh line.
    hello = "hello";
    for (int i = 0; i < 5; i++) step(hello[i], 1'b1);
    step(8'h0A, 1'b1); expect_all("rst.nl", 8'h00, 1, 0, 1);
    step(8'h00, 1'b1); chk("rst.h", out, "h");
    step(8'h00, 1'b1); chk("rst.e", out, "e");
    rst = 1'b0;
    step(8'h00, 1'b1); expect_all("rst.mid", 8'h00, 0, 0, 0);
    rst = 1'b1;
    step(8'h00, 1'b1); expect_all("rst.after", 8'h00, 0, 0, 0);
    step("q",   1'b1); expect_all("rst.q",  8'h00, 0, 0, 0);
    step(8'h0A, 1'b1); expect_all("rst.nlq", 8'h00, 1, 0, 1);
    step(8'h00, 1'b1); expect_all("rst.oq", "q",   0, 0, 1);
    step(8'h00, 1'b1); expect_all("rst.onl", 8'h0A, 0, 0, 0);
    step(8'h00, 1'b1); expect_all("rst.end", 8'h00, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/char_line_rx.md
# char_line_rx

Receive side of the 8-bit character stream, where 0 means idle and any nonzero value is one character per clock. The block collects characters into lines terminated by newline (8'h0A) using a ping-pong pair of line buffers. Each completed line is replayed on an output character stream of the same format, paced by a ready signal. It sits downstream of any character-producing block and decouples line assembly from a slower or stalled consumer.

## Interface
- DEPTH, 16: max characters per line, including the newline; power of two, ≥4.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in  in  8  input character; 8'h00 = no character this cycle.
- out  out  8  output character, registered; 8'h00 = idle.
- out_ready  in  1  consumer accepts a character at this edge.
- line_done  out  1  one-cycle pulse: a line was committed to the read bank.
- overflow  out  1  one-cycle pulse: a nonzero input character was dropped.
- busy  out  1  read bank draining or a committed line is pending.

## Operation
- Two banks of DEPTH×8. Write bank (index wsel) fills; the other bank drains.
- Write state machine:
  - FILL: nonzero `in` is stored at wptr and wptr increments.
    - Newline is stored, then the line is committed.
    - If wptr == DEPTH-1 and the char is not a newline: drop it, pulse overflow, go to DISCARD.
  - DISCARD: non-newline chars are dropped with an overflow pulse each. A newline is stored at wptr (DEPTH-1) and commits, so every line ends in 8'h0A.
  - PENDING: entered on commit when the read bank is not free. Every nonzero `in` is dropped with overflow. Leave when the read bank is free.
- Commit/swap: when the read bank is free, wsel flips, rlen ← wptr+1 (newline included), rptr ← 0, wptr ← 0, and FILL resumes.
- Read bank free = rlen == rptr, sampled before the edge.
- Read: on each edge where out_ready=1 and rptr < rlen, out ← bank[rptr] and rptr++. Otherwise out ← 0.
- busy = (rptr < rlen) | (state == PENDING).
- Reset values: out=0, line_done=0, overflow=0, busy=0, wptr=rptr=rlen=0, wsel=0, state FILL.

## Timing
- Newline sampled at edge e0 with the read bank free: swap at e0, line_done high for the cycle after e0, first char on out after e1 (with out_ready=1), one char per ready edge after that.
- With out_ready held high, an n-char line appears on n consecutive cycles starting 1 cycle after the newline edge.
- Commit while draining: swap happens on the edge after the last char is emitted, and line_done pulses then (not at newline time). The newline that caused PENDING is not dropped.
- Input is accepted every cycle in FILL/DISCARD, including the swap edge's following cycle. The char arriving on the swap edge itself is the committed newline.
- A one-char line (bare newline) is legal: rlen=1, output is a single 8'h0A.
- Reset mid-line or mid-drain: all partial data is discarded and out reads 0 from the next cycle.
- overflow and line_done may assert in the same cycle.

## Structure
- Package char_line_pkg: CHAR_IDLE=8'h00, CHAR_NL=8'h0A, write-state enum {FILL, DISCARD, PENDING}.
- Sub-module char_line_ram: 2·DEPTH×8 storage, one sync write port and one async read port, with the bank bit as the address MSB.
- FSM, pointers and output register live in char_line_rx.

## Test plan
- Reset low 10 cycles, then "x","y","z","\n" on consecutive cycles with out_ready=1 → line_done one cycle after "\n"; out = 'x','y','z',8'h0A on the next 4 cycles, then 0.
- Same line with out_ready toggling 1,0 → the four chars appear only after ready edges, order preserved, no duplicates; busy drops after 8'h0A.
- DEPTH=16, send 20 non-newline chars then "\n" → 15 chars stored, overflow pulses 5 times, output is the 15 chars plus 8'h0A.
- Line A ("ab\n") then immediately line B ("cd\n") with out_ready=0 → B enters PENDING. Release ready: "ab\n" emitted, then B's line_done, then "cd\n". A third line sent during PENDING produces overflow per char.
- Bare "\n" → single 8'h0A out, line_done once.
- Assert rst mid-drain of "hello\n" → out=0 from the next cycle, busy=0, and a new line "q\n" afterwards outputs correctly.
